// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx : byte-wide UART transmitter (8 data bits, LSB first, no parity,
//           STOP_BITS stop bits). One frame is sent per accepted tx_en strobe;
//           strobes that arrive while a frame is in flight are dropped.
//
// Parameters
//   CLKS_PER_BIT : clk_100 cycles per bit (>= 2)
//   STOP_BITS    : number of stop bits (1 or 2)
//
// Ports
//   clk_100 : system clock, rising edge
//   Reset   : synchronous, active-high reset; aborts any frame in flight
//   tx_en   : transmit strobe, sampled every cycle
//   tx_byte : byte to send, sampled only in the accept cycle
//   tx      : serial line, idles high
//   tx_busy : high from the cycle after accept until the frame completes
//   tx_done : one-cycle pulse on the edge where the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_100,
  input  logic       Reset,
  input  logic       tx_en,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  // Stop counter only needs to distinguish the first and second stop bit.
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [7:0]        shift_r, shift_s;
  logic [BAUD_W-1:0] baud_r,  baud_s;
  logic [2:0]        bit_r,   bit_s;
  logic              stop_r,  stop_s;
  logic              tx_r,    tx_s;
  logic              busy_r,  busy_s;
  logic              done_r,  done_s;
  logic              wrap_s;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port is driven straight from a flop.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    stop_s  = stop_r;
    tx_s    = tx_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    wrap_s  = (baud_r == BAUD_LAST);

    case (state_r)
      ST_IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        if (tx_en && !busy_r) begin
          shift_s = tx_byte;
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          stop_s  = 1'b0;
          tx_s    = 1'b0;
          busy_s  = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (wrap_s) begin
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          tx_s    = shift_r[0];
          state_s = ST_DATA;
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end

      ST_DATA: begin
        if (wrap_s) begin
          baud_s  = BAUD_ZERO;
          shift_s = {1'b0, shift_r[7:1]};
          bit_s   = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
            tx_s    = 1'b1;
            stop_s  = 1'b0;
            state_s = ST_STOP;
          end else begin
            // Next bit is shift_r[1], which becomes shift[0] after this shift.
            tx_s = shift_r[1];
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end

      ST_STOP: begin
        if (wrap_s) begin
          baud_s = BAUD_ZERO;
          if (stop_r == STOP_LAST) begin
            stop_s  = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            stop_s = stop_r + 1'b1;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end

      default: begin
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      shift_r <= 8'h00;
      baud_r  <= BAUD_ZERO;
      bit_r   <= 3'd0;
      stop_r  <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      stop_r  <= stop_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign tx      = tx_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx : self-checking bench for uart_tx. Two instances (1 and 2 stop
// bits, 4 clocks per bit) share one stimulus stream. A frame-level model
// predicts tx/tx_busy/tx_done from the cycle count since accept; a compare
// process checks both instances every cycle, and directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk_100 = 1'b0;
  logic       Reset;
  logic       tx_en;
  logic [7:0] tx_byte;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk_100(clk_100), .Reset(Reset), .tx_en(tx_en), .tx_byte(tx_byte),
    .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk_100(clk_100), .Reset(Reset), .tx_en(tx_en), .tx_byte(tx_byte),
    .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  always #5 clk_100 = ~clk_100;

  int checks = 0;
  int errors = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model: index 0 = one stop bit, index 1 = two stop bits.
  // ---------------------------------------------------------------------------
  int         frame_len [2];
  bit         active    [2];
  int         n         [2];
  logic [7:0] mbyte     [2];
  logic       exp_tx    [2];
  logic       exp_busy  [2];
  logic       exp_done  [2];
  int         done_cnt  [2];
  bit         cmp_on = 1'b0;

  // Line level at bit slot idx of a frame: start, 8 data LSB first, then stop.
  function automatic logic line_at(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  initial begin
    frame_len[0] = 10 * CPB;
    frame_len[1] = 11 * CPB;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; n[i] = 0; mbyte[i] = 8'h00;
      exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
      done_cnt[i] = 0;
    end
  end

  // Model update on every active edge from the inputs present at that edge.
  always @(posedge clk_100) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        active[i] = 1'b0;
        exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
      end else if (active[i]) begin
        n[i] = n[i] + 1;
        if (n[i] == frame_len[i]) begin
          active[i] = 1'b0;
          exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b1;
        end else begin
          exp_tx[i] = line_at(mbyte[i], n[i] / CPB);
          exp_busy[i] = 1'b1; exp_done[i] = 1'b0;
        end
      end else if (tx_en) begin
        active[i] = 1'b1; n[i] = 0; mbyte[i] = tx_byte;
        exp_tx[i] = 1'b0; exp_busy[i] = 1'b1; exp_done[i] = 1'b0;
      end else begin
        exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk_100) begin
    if (cmp_on) begin
      check_bit("tx_a",   tx_a,   exp_tx[0]);
      check_bit("busy_a", busy_a, exp_busy[0]);
      check_bit("done_a", done_a, exp_done[0]);
      check_bit("tx_b",   tx_b,   exp_tx[1]);
      check_bit("busy_b", busy_b, exp_busy[1]);
      check_bit("done_b", done_b, exp_done[1]);
      if (done_a === 1'b1) done_cnt[0]++;
      if (done_b === 1'b1) done_cnt[1]++;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture helper: sample j = 0 is the falling edge right after accept.
  // ---------------------------------------------------------------------------
  logic cap_tx  [0:127];
  logic cap_txb [0:127];
  int   cap_busy [2];
  int   cap_done [2];
  int   cap_done_at;

  task automatic capture(input int ncyc, input bit hold, input int s1, input int s2,
                         input logic [7:0] sb);
    cap_busy[0] = 0; cap_busy[1] = 0; cap_done[0] = 0; cap_done[1] = 0;
    cap_done_at = -1;
    for (int j = 0; j < ncyc; j++) begin
      cap_tx[j]  = tx_a;
      cap_txb[j] = tx_b;
      if (busy_a === 1'b1) cap_busy[0]++;
      if (busy_b === 1'b1) cap_busy[1]++;
      if (done_a === 1'b1) begin
        cap_done[0]++;
        if (cap_done_at < 0) cap_done_at = j;
      end
      if (done_b === 1'b1) cap_done[1]++;
      if (j == s1 || j == s2) begin
        tx_en = 1'b1; tx_byte = sb;
      end else begin
        tx_en = hold;
      end
      @(negedge clk_100);
    end
    tx_en = 1'b0;
  endtask

  // Reassemble a byte from instance-a samples by reading each data bit mid-slot.
  function automatic logic [7:0] decode(input int base);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = cap_tx[base + (k + 1) * CPB + CPB / 2];
    return d;
  endfunction

  task automatic accept(input logic [7:0] b);
    tx_en = 1'b1; tx_byte = b;
    @(negedge clk_100);
    tx_en = 1'b0;
  endtask

  logic [9:0] seq_a5;
  int         stop_hi;
  int         dc0, dc1;

  initial begin
    Reset = 1'b1; tx_en = 1'b1; tx_byte = 8'hFF;
    seq_a5 = 10'b1101001010;

    // Reset held with an active strobe: no frame may start.
    @(posedge clk_100);
    cmp_on = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_100);
      check_bit("rst_tx",   tx_a,   1'b1);
      check_bit("rst_busy", busy_a, 1'b0);
      check_bit("rst_done", done_a, 1'b0);
      check_bit("rst_busy_b", busy_b, 1'b0);
    end
    Reset = 1'b0; tx_en = 1'b0;
    repeat (3) @(negedge clk_100);

    // Single frame 8'hA5.
    accept(8'hA5);
    capture(48, 1'b0, -1, -1, 8'h00);
    for (int k = 0; k < 10; k++) check_int("a5_bit", int'(cap_tx[k * CPB + 2]), int'(seq_a5[k]));
    check_int("a5_busy_len_a", cap_busy[0], 40);
    check_int("a5_busy_len_b", cap_busy[1], 44);
    check_int("a5_done_at",    cap_done_at, 40);
    check_int("a5_done_n",     cap_done[0], 1);

    // Two stop bits with 8'h01.
    accept(8'h01);
    capture(48, 1'b0, -1, -1, 8'h00);
    check_int("s2_busy_len", cap_busy[1], 44);
    check_bit("s2_bit7", cap_txb[35], 1'b0);
    stop_hi = 0;
    for (int j = 36; j < 44; j++) if (cap_txb[j] === 1'b1) stop_hi++;
    check_int("s2_stop_hi", stop_hi, 8);
    check_int("s2_done_n", cap_done[1], 1);

    // Strobes while busy are dropped.
    accept(8'h3C);
    capture(50, 1'b0, 5, 20, 8'hFF);
    check_int("busy_byte",   int'(decode(0)), 32'h3C);
    check_int("busy_done_a", cap_done[0], 1);
    check_int("busy_done_b", cap_done[1], 1);

    // Back-to-back with tx_en held high.
    tx_en = 1'b1; tx_byte = 8'h00;
    @(negedge clk_100);
    tx_byte = 8'hFF;
    capture(90, 1'b1, -1, -1, 8'h00);
    check_int("b2b_byte0", int'(decode(0)),  32'h00);
    check_bit("b2b_stop",  cap_tx[39], 1'b1);
    check_bit("b2b_idle",  cap_tx[40], 1'b1);
    check_bit("b2b_start", cap_tx[41], 1'b0);
    check_int("b2b_byte1", int'(decode(41)), 32'hFF);
    repeat (60) @(negedge clk_100);

    // Reset during data bit 3 of 8'h81.
    accept(8'h81);
    repeat (17) @(negedge clk_100);
    dc0 = done_cnt[0]; dc1 = done_cnt[1];
    Reset = 1'b1;
    @(negedge clk_100);
    check_bit("mid_rst_tx",   tx_a,   1'b1);
    check_bit("mid_rst_busy", busy_a, 1'b0);
    check_bit("mid_rst_tx_b", tx_b,   1'b1);
    Reset = 1'b0;
    repeat (60) @(negedge clk_100);
    check_int("mid_rst_nodone_a", done_cnt[0], dc0);
    check_int("mid_rst_nodone_b", done_cnt[1], dc1);
    accept(8'h55);
    capture(48, 1'b0, -1, -1, 8'h00);
    check_int("after_rst_byte", int'(decode(0)), 32'h55);
    check_int("after_rst_done", cap_done[0], 1);

    // Randomized traffic, including occasional resets, checked by the model.
    for (int c = 0; c < 1500; c++) begin
      Reset   = ($urandom_range(0, 199) == 0);
      tx_en   = ($urandom_range(0, 2) == 0);
      tx_byte = 8'($urandom);
      @(negedge clk_100);
    end
    Reset = 1'b0; tx_en = 1'b0;
    repeat (60) @(negedge clk_100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, 8N1 by default, serialising one byte per `tx_en` strobe onto the host serial line. It is the transmit end of the host link. The control FSM reads fifo2 and pulses `tx_en` with the byte on `tx_byte`, using `tx_busy` to pace reads. Frame format mirrors the receiver: one start bit, 8 data bits LSB first, no parity, STOP_BITS stop bits.

## Interface
- `CLKS_PER_BIT`, default 868: clk_100 cycles per bit (100 MHz / 115200 baud); legal values ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk_100`  input  1  system clock, 100 MHz; all logic is on the rising edge.
- `Reset`  input  1  reset, synchronous, active-high.
- `tx_en`  input  1  transmit strobe; sampled every cycle.
- `tx_byte`  input  8  byte to send; sampled only in the accept cycle.
- `tx`  output  1  serial line; idle high.
- `tx_busy`  output  1  high from the cycle after accept until the frame completes.
- `tx_done`  output  1  one-cycle pulse when the last stop bit ends.

## Operation
- States: IDLE, START, DATA, STOP. All outputs are registered.
- **Reset values:** tx=1, tx_busy=0, tx_done=0, state=IDLE, shift register=0, baud counter=0, bit counter=0, stop counter=0.
- **IDLE:** tx=1.
  - If tx_en=1 and tx_busy=0: latch tx_byte into the shift register, clear the baud counter, go to START.
  - tx_en=0: remain in IDLE.
- **START:** tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- **DATA:** tx=shift[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit: shift right, increment the bit counter.
  - After bit 7 ends, go to STOP.
- **STOP:** tx=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
  - tx_busy falls and tx_done pulses on that same edge.
- Baud counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT−1, then wraps to 0.
  - The wrap marks the end of a bit.
- **tx_en while tx_busy=1:** ignored. tx_byte is not sampled and the frame in flight is undisturbed. No queueing; a dropped strobe is lost.
- **tx_en held high continuously:** a new frame is accepted in the first cycle tx_busy is low, so frames go back-to-back. Each frame is separated only by the single IDLE cycle.
- tx_byte changes after accept have no effect on the current frame.
- **Reset mid-frame:** the frame is aborted.
  - tx=1 on the next edge.
  - All counters clear, and tx_done does not pulse.

## Timing
- tx_en=1 and tx_busy=0 sampled at edge E0 (the accept cycle is the cycle ending at E0).
- **From E0:** tx=0 and tx_busy=1 are valid.
- **From E0 + CLKS_PER_BIT:** data bit 0 is on tx.
- **From E0 + (1+k)×CLKS_PER_BIT:** data bit k is on tx, for k = 0..7.
- **From E0 + 9×CLKS_PER_BIT:** the first stop bit is on tx.
- **At E0 + (9+STOP_BITS)×CLKS_PER_BIT:** tx_busy=0 and tx_done=1.
  - tx_done=1 lasts exactly one cycle.
  - tx stays 1.
- **Frame length:** tx_busy high for (9+STOP_BITS)×CLKS_PER_BIT cycles.
- **Minimum accept-to-accept spacing:** (9+STOP_BITS)×CLKS_PER_BIT + 1 cycles.
- **Controller pacing:** the controller strobes tx_en the cycle after fifo rd_ack. tx_busy rises one cycle after accept, so a rd_en2 issued in the accept cycle itself is allowed. That byte is presented with the next strobe.

## Test plan
- **Reset values:** assert Reset for 3 cycles with tx_en=1 and tx_byte=8'hFF -> tx=1, tx_busy=0, tx_done=0 throughout. No frame starts while Reset=1.
- **Single frame:** CLKS_PER_BIT=4, STOP_BITS=1, one tx_en pulse with 8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_busy high 40 cycles. tx_done pulses once at cycle 40.
- **Strobe while busy:** 8'h3C accepted, then tx_en pulses with 8'hFF at cycles 5 and 20 -> the frame on tx is 8'h3C only. Exactly one tx_done pulse.
- **Back-to-back:** tx_en held high, tx_byte=8'h00 then 8'hFF after the first accept -> two frames. One idle-high cycle between the stop bit and the next start bit. Decoded bytes are 00, FF.
- **Reset mid-frame:** Reset=1 during data bit 3 of 8'h81 -> tx=1, tx_busy=0, no tx_done. A following 8'h55 frame is sent correctly.
- **Two stop bits:** STOP_BITS=2, CLKS_PER_BIT=4, 8'h01 -> tx_busy high 44 cycles. The stop level is held 8 cycles.
